// File: rtl/pulse_fifo_plotter_if.sv
// SDRAM framebuffer write channel between a plotter client and the SDRAM
// controller: one pixel write per req, acknowledged by a one-cycle done pulse.
interface pulse_fifo_plotter_if;
  logic [23:0] oSDRAM_Wr_Addr;
  logic [15:0] oSDRAM_Wr_Data;
  logic        oSDRAM_Wr_Req;
  logic        iSDRAM_Wr_Done;

  modport master (
    output oSDRAM_Wr_Addr,
    output oSDRAM_Wr_Data,
    output oSDRAM_Wr_Req,
    input  iSDRAM_Wr_Done
  );

  modport slave (
    input  oSDRAM_Wr_Addr,
    input  oSDRAM_Wr_Data,
    input  oSDRAM_Wr_Req,
    output iSDRAM_Wr_Done
  );
endinterface

// File: rtl/pulse_fifo_plotter.sv
// Pops one photon count per scheduled job from the pulse-counter FIFO and
// paints it as a vertical bar column into the SDRAM framebuffer. Columns
// scroll left to right and wrap at WIDTH.
module pulse_fifo_plotter #(
  parameter int unsigned WIDTH       = 480,
  parameter int unsigned HEIGHT      = 272,
  parameter int unsigned SCALE_SHIFT = 4,
  parameter logic [15:0] FG_COLOR    = 16'hFFE0,
  parameter logic [15:0] BG_COLOR    = 16'h0000,
  parameter logic [1:0]  BANK        = 2'b00
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        iSchedule,
  output logic                        oDone,
  input  logic                        fifo_empty,
  output logic                        fifo_rd,
  input  logic [31:0]                 fifo_data,
  pulse_fifo_plotter_if.master        sdram,
  output logic [8:0]                  o_x,
  output logic                        o_clip
);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    PIX_REQ,
    PIX_WAIT,
    DONE,
    RELEASE
  } state_t;

  localparam logic [9:0] H_FULL = 10'(HEIGHT);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);
  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  height;
  logic [8:0]  y;
  logic [31:0] scaled;
  logic        saturated;
  logic [9:0]  fg_start;
  logic        last_row;
  logic        last_col;

  assign scaled    = fifo_data >> SCALE_SHIFT;
  assign saturated = (scaled > 32'(HEIGHT));
  // Rows at or below fg_start (counting from the top) belong to the bar.
  assign fg_start  = H_FULL - height;
  assign last_row  = (y == Y_LAST);
  assign last_col  = (o_x == X_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; fifo_rd and oDone are single-state strobes.
  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    oDone     = 1'b0;
    case (state)
      IDLE: begin
        if (iSchedule) begin
          state_nxt = (en && !fifo_empty) ? POP : DONE;
        end
      end
      POP: begin
        fifo_rd   = 1'b1;
        state_nxt = LATCH;
      end
      LATCH:   state_nxt = PIX_REQ;
      PIX_REQ: state_nxt = PIX_WAIT;
      PIX_WAIT: begin
        if (sdram.iSDRAM_Wr_Done) begin
          state_nxt = last_row ? DONE : PIX_REQ;
        end
      end
      DONE: begin
        oDone     = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!iSchedule) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Column datapath: latch bar height, issue one pixel write per row, advance x.
  // The write request is registered in PIX_REQ so it is seen during PIX_WAIT;
  // returning to PIX_REQ after done therefore always leaves req low one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      height               <= '0;
      y                    <= '0;
      o_x                  <= '0;
      o_clip               <= 1'b0;
      sdram.oSDRAM_Wr_Addr <= '0;
      sdram.oSDRAM_Wr_Data <= '0;
      sdram.oSDRAM_Wr_Req  <= 1'b0;
    end else begin
      case (state)
        LATCH: begin
          height <= saturated ? H_FULL : scaled[9:0];
          o_clip <= saturated;
          y      <= '0;
        end
        PIX_REQ: begin
          sdram.oSDRAM_Wr_Addr <= {BANK, 4'b0000, y, o_x};
          sdram.oSDRAM_Wr_Data <= ({1'b0, y} >= fg_start) ? FG_COLOR : BG_COLOR;
          sdram.oSDRAM_Wr_Req  <= 1'b1;
        end
        PIX_WAIT: begin
          if (sdram.iSDRAM_Wr_Done) begin
            sdram.oSDRAM_Wr_Req <= 1'b0;
            if (last_row) begin
              o_x <= last_col ? '0 : o_x + 9'd1;
            end else begin
              y <= y + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_fifo_plotter.sv
// Bench for pulse_fifo_plotter: FIFO and SDRAM controller models around the
// DUT, with every rendered column compared against a per-job bar model.
module tb_pulse_fifo_plotter;

  localparam int unsigned W     = 8;
  localparam int unsigned H     = 272;
  localparam int unsigned SH    = 4;
  localparam logic [15:0] FG    = 16'hFFE0;
  localparam logic [15:0] BG    = 16'h0000;
  localparam int unsigned LIMIT = 10000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        sched = 1'b0;
  logic        done_w;
  logic        fifo_rd;
  logic        fifo_empty;
  logic [31:0] fifo_data = '0;
  logic [8:0]  o_x;
  logic        o_clip;

  pulse_fifo_plotter_if sdram ();

  pulse_fifo_plotter #(
    .WIDTH(W),
    .HEIGHT(H),
    .SCALE_SHIFT(SH),
    .FG_COLOR(FG),
    .BG_COLOR(BG),
    .BANK(2'b00)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .iSchedule(sched),
    .oDone(done_w),
    .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd),
    .fifo_data(fifo_data),
    .sdram(sdram),
    .o_x(o_x),
    .o_clip(o_clip)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // FIFO model: written by the stimulus, read on fifo_rd (data valid next cycle).
  logic [31:0] fifo_mem [0:63];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned rd_cnt = 0;
  int unsigned underflow = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  // Standard-read FIFO pop.
  always @(posedge clk) begin
    if (fifo_rd === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_ptr == wr_ptr) begin
        underflow <= underflow + 1;
      end else begin
        fifo_data <= fifo_mem[rd_ptr % 64];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // oDone pulse counter.
  int unsigned done_cnt = 0;
  always @(posedge clk) begin
    if (done_w === 1'b1) done_cnt <= done_cnt + 1;
  end

  // SDRAM controller model: logs every accepted write, returns done after a
  // random delay, and watches addr/data/req stability and the req gap.
  logic [23:0] wa_q [$];
  logic [15:0] wd_q [$];
  int unsigned dly_min = 1;
  int unsigned dly_max = 1;
  int unsigned unstable = 0;
  int unsigned nogap = 0;

  initial begin : responder
    logic [23:0] a;
    logic [15:0] d;
    int unsigned dly;
    sdram.iSDRAM_Wr_Done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sdram.oSDRAM_Wr_Req === 1'b1) begin
        a   = sdram.oSDRAM_Wr_Addr;
        d   = sdram.oSDRAM_Wr_Data;
        dly = $urandom_range(dly_max, dly_min);
        for (int unsigned k = 1; k < dly; k++) begin
          @(posedge clk); #1;
          if (rst_n === 1'b1 && (sdram.oSDRAM_Wr_Addr !== a || sdram.oSDRAM_Wr_Data !== d ||
                                 sdram.oSDRAM_Wr_Req !== 1'b1)) unstable++;
        end
        wa_q.push_back(a);
        wd_q.push_back(d);
        sdram.iSDRAM_Wr_Done = 1'b1;
        @(posedge clk); #1;
        sdram.iSDRAM_Wr_Done = 1'b0;
        if (sdram.oSDRAM_Wr_Req !== 1'b0) nogap++;
      end
    end
  end

  int unsigned model_x    = 0;
  bit          model_clip = 1'b0;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // One scheduled job; draw says whether a column is expected for word cnt.
  task automatic do_job(input string tag, input bit draw, input logic [31:0] cnt,
                        output int unsigned base);
    int unsigned rd0, dn0, cyc, nw, bad, h;
    logic [31:0] s;
    base = wa_q.size();
    rd0  = rd_cnt;
    dn0  = done_cnt;
    cyc  = 0;
    sched = 1'b1;
    while (done_w !== 1'b1 && cyc < LIMIT) begin
      tick(1);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(cyc < LIMIT), 32'd1);
    if (!draw) check({tag, "_done_latency"}, 32'(cyc <= 2), 32'd1);
    tick(4);
    check({tag, "_done_pulses"}, done_cnt - dn0, 32'd1);
    sched = 1'b0;
    tick(3);
    check({tag, "_rd_pulses"}, rd_cnt - rd0, draw ? 32'd1 : 32'd0);
    nw = wa_q.size() - base;
    check({tag, "_writes"}, nw, draw ? H : 32'd0);
    if (draw) begin
      s = cnt >> SH;
      h = (s > H) ? H : s;
      model_clip = (s > H);
      bad = 0;
      for (int unsigned i = 0; i < nw; i++) begin
        if (wa_q[base + i] !== {2'b00, 4'b0000, 9'(i), 9'(model_x)} ||
            wd_q[base + i] !== ((i >= H - h) ? FG : BG)) bad++;
      end
      check({tag, "_bad_pixels"}, bad, 32'd0);
      model_x = (model_x + 1) % W;
    end
    check({tag, "_o_x"}, o_x, model_x);
    check({tag, "_o_clip"}, o_clip, model_clip);
  endtask

  initial begin : stimulus
    int unsigned base, cyc;
    logic [31:0] c;

    // Reset state.
    tick(3);
    check("rst_oDone", done_w, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_req", sdram.oSDRAM_Wr_Req, 0);
    check("rst_addr", sdram.oSDRAM_Wr_Addr, 0);
    check("rst_data", sdram.oSDRAM_Wr_Data, 0);
    check("rst_o_x", o_x, 0);
    check("rst_o_clip", o_clip, 0);
    rst_n = 1'b1;
    tick(2);

    // Count 0x320 -> 50-row bar, done returned 2 cycles after each req.
    en = 1'b1;
    dly_min = 2;
    dly_max = 2;
    push_word(32'h0000_0320);
    tick(2);
    do_job("t320", 1'b1, 32'h0000_0320, base);
    check("t320_y221_bg", wd_q[base + 221], BG);
    check("t320_y222_fg", wd_q[base + 222], FG);
    check("t320_o_x_is1", o_x, 1);

    // Saturated and empty bars.
    push_word(32'hFFFF_FFFF);
    tick(2);
    do_job("tsat", 1'b1, 32'hFFFF_FFFF, base);
    check("tsat_clip", o_clip, 1);
    push_word(32'h0000_000F);
    tick(2);
    do_job("tzero", 1'b1, 32'h0000_000F, base);
    check("tzero_clip", o_clip, 0);

    // Empty FIFO and disabled block both finish as empty jobs.
    do_job("empty", 1'b0, '0, base);
    en = 1'b0;
    push_word(32'h0000_1000);
    tick(2);
    do_job("en_off", 1'b0, '0, base);
    en = 1'b1;
    do_job("en_on", 1'b1, 32'h0000_1000, base);

    // Random write latencies 1..20 cycles.
    dly_min = 1;
    dly_max = 20;
    for (int unsigned j = 0; j < 2; j++) begin
      c = $urandom() >> $urandom_range(31, 18);
      push_word(c);
      tick(2);
      do_job("rand_dly", 1'b1, c, base);
    end
    check("rand_dly_stable", unstable, 0);
    check("rand_dly_req_gap", nogap, 0);

    // Reset while row 100 is being written.
    dly_min = 1;
    dly_max = 1;
    push_word(32'h0000_0800);
    tick(2);
    base  = wa_q.size();
    cyc   = 0;
    sched = 1'b1;
    while (wa_q.size() - base < 100 && cyc < LIMIT) begin
      tick(1);
      cyc++;
    end
    check("mid_rst_reached_y100", 32'(cyc < LIMIT), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", sdram.oSDRAM_Wr_Req, 0);
    check("mid_rst_fifo_rd", fifo_rd, 0);
    check("mid_rst_oDone", done_w, 0);
    check("mid_rst_o_x", o_x, 0);
    sched = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    model_x    = 0;
    model_clip = 1'b0;
    c = $urandom() >> $urandom_range(31, 18);
    push_word(c);
    tick(2);
    do_job("post_rst", 1'b1, c, base);
    check("post_rst_first_addr", wa_q[base], 24'h000000);

    // Column wrap: W+1 jobs from x=0.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    model_x    = 0;
    model_clip = 1'b0;
    for (int unsigned j = 0; j < W + 1; j++) begin
      c = $urandom() >> $urandom_range(31, 18);
      push_word(c);
      tick(2);
      do_job("wrap", 1'b1, c, base);
      if (j == W - 1) check("wrap_o_x_zero", o_x, 0);
    end
    check("wrap_last_col_x0", wa_q[base][8:0], 0);
    check("wrap_o_x_one", o_x, 1);

    check("fifo_underflow", underflow, 0);
    check("final_stable", unstable, 0);
    check("final_req_gap", nogap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
